// File: rtl/drive_sequencer.sv
// Turns the tone-detector direction code into timed PWM/direction maneuvers
// for a two-wheel H-bridge drive: cruise, stop, and fixed-length pivots.
module drive_sequencer #(
  parameter int unsigned PWM_PERIOD  = 2500,
  parameter int unsigned DUTY_FWD    = 1875,
  parameter int unsigned DUTY_TURN   = 1250,
  parameter int unsigned TURN_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tdDIR,
  output logic       motor_l_pwm,
  output logic       motor_r_pwm,
  output logic       motor_l_dir,
  output logic       motor_r_dir,
  output logic       busy,
  output logic       maneuver_done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_TURN_L = 3'd2,
    ST_TURN_R = 3'd3,
    ST_BACK   = 3'd4
  } state_t;

  localparam logic [31:0] LIM_TURN    = 32'(TURN_CYCLES) - 32'd1;
  localparam logic [31:0] LIM_BACK    = (32'(TURN_CYCLES) * 32'd2) - 32'd1;
  localparam logic [31:0] PERIOD_LAST = 32'(PWM_PERIOD) - 32'd1;
  localparam logic [2:0]  CODE_STOP   = 3'b100;

  function automatic state_t decode(input logic [2:0] code);
    if (code[2]) begin
      return ST_IDLE;
    end else begin
      case (code[1:0])
        2'b00:   return ST_FWD;
        2'b01:   return ST_TURN_L;
        2'b10:   return ST_TURN_R;
        default: return ST_BACK;
      endcase
    end
  endfunction

  state_t      r_state;
  logic [2:0]  r_td_q;
  logic [2:0]  r_td_last;
  logic        r_pend_valid;
  logic [2:0]  r_pend_code;
  logic [31:0] r_man_cnt;
  logic [31:0] r_pwm_cnt;
  logic        r_done_evt;

  state_t      w_state_nxt;
  logic [2:0]  w_td_last_nxt;
  logic        w_pend_valid_nxt;
  logic [2:0]  w_pend_code_nxt;
  logic        w_enter;
  logic        w_done;
  logic        w_is_new;
  logic        w_pivot;
  logic        w_at_limit;
  logic [31:0] w_duty;
  logic        w_l_dir;
  logic        w_r_dir;

  assign w_is_new   = (r_td_q != r_td_last);
  assign w_pivot    = (r_state == ST_TURN_L) || (r_state == ST_TURN_R) || (r_state == ST_BACK);
  assign w_at_limit = (r_state == ST_BACK) ? (r_man_cnt == LIM_BACK) : (r_man_cnt == LIM_TURN);

  // Next-state, command acceptance and pending-command bookkeeping.
  always_comb begin
    w_state_nxt      = r_state;
    w_td_last_nxt    = r_td_last;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_code_nxt  = r_pend_code;
    w_enter          = 1'b0;
    w_done           = 1'b0;
    case (r_state)
      ST_IDLE, ST_FWD: begin
        if (w_is_new) begin
          w_td_last_nxt = r_td_q;
          w_state_nxt   = decode(r_td_q);
          w_enter       = 1'b1;
        end else begin
          w_enter = 1'b0;
        end
      end
      ST_TURN_L, ST_TURN_R, ST_BACK: begin
        if (w_is_new && r_td_q[2]) begin
          w_td_last_nxt    = r_td_q;
          w_state_nxt      = ST_IDLE;
          w_pend_valid_nxt = 1'b0;
          w_done           = 1'b1;
          w_enter          = 1'b1;
        end else if (w_is_new) begin
          // A fresh code on the completion cycle replaces any older pending one.
          w_td_last_nxt = r_td_q;
          if (w_at_limit) begin
            w_state_nxt      = decode(r_td_q);
            w_pend_valid_nxt = 1'b0;
            w_done           = 1'b1;
            w_enter          = 1'b1;
          end else begin
            w_pend_valid_nxt = 1'b1;
            w_pend_code_nxt  = r_td_q;
          end
        end else if (w_at_limit) begin
          w_done           = 1'b1;
          w_enter          = 1'b1;
          w_pend_valid_nxt = 1'b0;
          if (r_pend_valid) begin
            w_state_nxt = decode(r_pend_code);
          end else begin
            w_state_nxt = ST_FWD;
          end
        end else begin
          w_enter = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_enter     = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_duty  = 32'd0;
    w_l_dir = 1'b1;
    w_r_dir = 1'b1;
    case (r_state)
      ST_FWD:    w_duty = 32'(DUTY_FWD);
      ST_TURN_L: begin w_duty = 32'(DUTY_TURN); w_l_dir = 1'b0; end
      ST_TURN_R: begin w_duty = 32'(DUTY_TURN); w_r_dir = 1'b0; end
      ST_BACK:   begin w_duty = 32'(DUTY_TURN); w_l_dir = 1'b0; end
      default:   w_duty = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_td_q       <= CODE_STOP;
      r_td_last    <= CODE_STOP;
      r_pend_valid <= 1'b0;
      r_pend_code  <= CODE_STOP;
      r_man_cnt    <= 32'd0;
      r_pwm_cnt    <= 32'd0;
      r_done_evt   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_td_q       <= tdDIR;
      r_td_last    <= w_td_last_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_code  <= w_pend_code_nxt;
      r_man_cnt    <= (w_enter || !w_pivot) ? 32'd0 : (r_man_cnt + 32'd1);
      r_pwm_cnt    <= (r_pwm_cnt == PERIOD_LAST) ? 32'd0 : (r_pwm_cnt + 32'd1);
      r_done_evt   <= w_done;
    end
  end

  // Output stage: the done pulse lines up with the first cycle of the new outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      motor_l_pwm   <= 1'b0;
      motor_r_pwm   <= 1'b0;
      motor_l_dir   <= 1'b1;
      motor_r_dir   <= 1'b1;
      busy          <= 1'b0;
      maneuver_done <= 1'b0;
    end else begin
      motor_l_pwm   <= (r_pwm_cnt < w_duty);
      motor_r_pwm   <= (r_pwm_cnt < w_duty);
      motor_l_dir   <= w_l_dir;
      motor_r_dir   <= w_r_dir;
      busy          <= w_pivot;
      maneuver_done <= r_done_evt;
    end
  end

endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

Consumes the 3-bit direction code from the tone detection stage and turns it into timed motor maneuvers for the two-wheel drive. It sits directly downstream of tone detection and directly drives the H-bridge inputs (PWM plus direction per wheel). It executes fixed-length pivots for LEFT, RIGHT and BACK, cruises on STRAIGHT, and halts on STOP.

## Interface
- PWM_PERIOD, 2500: PWM period in clk cycles (20 kHz at 50 MHz).
- DUTY_FWD, 1875: high cycles per period while cruising.
- DUTY_TURN, 1250: high cycles per period during pivots.
- TURN_CYCLES, 25_000_000: LEFT/RIGHT pivot length in cycles. BACK lasts 2*TURN_CYCLES.
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tdDIR  input  3  direction code, level-held by the upstream stage:
  - 100: STOP. Any code with bit2=1 is treated as STOP.
  - 000: STRAIGHT.
  - 001: LEFT.
  - 010: RIGHT.
  - 011: BACK.
- motor_l_pwm  output  1  left wheel enable PWM.
- motor_r_pwm  output  1  right wheel enable PWM.
- motor_l_dir  output  1  left wheel direction, 1 = forward.
- motor_r_dir  output  1  right wheel direction, 1 = forward.
- busy  output  1  high while a timed pivot (TURN_L, TURN_R, BACK) is executing.
- maneuver_done  output  1  one-cycle pulse when a timed pivot completes or is aborted.

## Operation
- **Input capture.** tdDIR is registered every cycle into td_q. A command is "new" when td_q differs from the last accepted code, td_last. A code held constant is never re-executed.
- **States:**
  - IDLE: both PWM 0, both dir 1.
  - FWD: both dir 1, both PWM at DUTY_FWD.
  - TURN_L: left dir 0, right dir 1, PWM at DUTY_TURN.
  - TURN_R: left dir 1, right dir 0, PWM at DUTY_TURN.
  - BACK: same as TURN_L, for 2*TURN_CYCLES.
- **New command in IDLE or FWD:** accepted immediately and td_last <= td_q.
  - STOP -> IDLE.
  - STRAIGHT -> FWD.
  - LEFT -> TURN_L.
  - RIGHT -> TURN_R.
  - BACK -> BACK.
- **New command during TURN_L/TURN_R/BACK:**
  - STOP: aborts at once. Next state is IDLE, the maneuver_done pulse fires, and the pending register is cleared.
  - Any other code: stored in a one-deep pending register (pend_valid, pend_code) and td_last <= td_q. A later change overwrites the pending code (last wins).
- **Pivot completion:** when the 32-bit maneuver counter reaches its limit minus 1 (TURN_CYCLES-1, or 2*TURN_CYCLES-1 for BACK):
  - maneuver_done pulses.
  - If pend_valid, the pending code is dispatched as if newly accepted, and pend_valid clears.
  - Otherwise the next state is FWD.
  - A pending code identical to the completed pivot restarts that pivot with the counter reset to 0.
- **Counters:**
  - The maneuver counter clears on every state entry.
  - The PWM counter runs freely from 0 to PWM_PERIOD-1 and wraps to 0. It is never cleared by state changes.
  - PWM output is high when pwm_cnt < duty. duty=0 means always low; duty>=PWM_PERIOD means always high.
- **Simultaneous events:** if a new non-STOP code arrives on the same cycle as pivot completion, the new code wins and the old pending code is discarded. If STOP arrives on the completion cycle, the next state is IDLE.

## Timing
- Reset, on any clk edge with rst=1, including mid-maneuver:
  - state=IDLE, td_q=100, td_last=100, pend_valid=0.
  - Both counters 0.
  - motor_*_pwm=0, motor_*_dir=1, busy=0, maneuver_done=0.
- After rst falls, a tdDIR value other than 100 is treated as a new command.
- Latency: tdDIR sampled into td_q at edge E0 -> state updates at E1 -> all outputs (registered) reflect it after E2. Total: 2 cycles from the sampling edge.
- busy is registered from state and has the same 2-cycle latency.
- Pivot duration, measured from dir outputs changing to dir outputs changing again: exactly TURN_CYCLES cycles, or 2*TURN_CYCLES for BACK.
- maneuver_done is registered and is high during the first cycle the new state's outputs appear.

## Test plan
All scenarios use PWM_PERIOD=10, DUTY_FWD=7, DUTY_TURN=5, TURN_CYCLES=20.

1. **Reset and cruise.** Reset with tdDIR=100, release rst, then set tdDIR=000 -> outputs: dir=1/1, each PWM high 7 of every 10 cycles, and dir/PWM begin 2 cycles after the sampling edge.
2. **LEFT pivot.** LEFT from FWD -> l_dir=0, r_dir=1, PWM 5/10, busy=1 for exactly 20 cycles, then maneuver_done pulse, FWD, busy=0.
3. **BACK then pending RIGHT.** BACK, then tdDIR changed to 010 at cycle 10 of the pivot -> BACK runs the full 40 cycles, then TURN_R for 20 cycles, then FWD. Exactly two done pulses.
4. **STOP abort.** STOP at cycle 5 of TURN_R -> IDLE 2 cycles after sampling, PWM 0, one done pulse, and no FWD afterwards.
5. **Pending overwrite.** During TURN_L, tdDIR goes 001->000->010 -> after TURN_L completes, TURN_R executes. STRAIGHT is discarded.
6. **Reset mid-pivot.** rst mid-BACK -> all outputs at reset values next cycle. A held tdDIR=011 after release restarts BACK.
